voice_allocator: RTL and testbench

//   Polyphonic voice scheduler between the MIDI byte stream and a bank of voice instances.

---
 rtl/voice_allocator.sv | 176 +++++++++++++++++
 tb/tb_voice_allocator.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: parses one MIDI channel's note-on/off and all-notes-off
// messages and assigns notes to NUM_VOICES voices, stealing the oldest when all are busy.
module voice_allocator #(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned AGE_BITS   = 8,
  parameter int unsigned CHANNEL    = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                midi_data,
  input  logic                      midi_valid,
  output logic [7*NUM_VOICES-1:0]   voice_note,
  output logic [7*NUM_VOICES-1:0]   voice_velocity,
  output logic [NUM_VOICES-1:0]     voice_gate,
  output logic [NUM_VOICES-1:0]     voice_trigger,
  output logic                      steal_event
);

  localparam int unsigned IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [AGE_BITS-1:0] AGE_MAX = '1;

  typedef enum logic [1:0] {ST_STATUS, ST_D1, ST_D2, ST_EXEC} state_e;

  state_e                state_q, state_d;
  logic [7:0]            status_q, status_d;
  logic                  rs_valid_q, rs_valid_d;
  logic [6:0]            d1_q, d1_d;
  logic [6:0]            note_q [NUM_VOICES];
  logic [6:0]            note_d [NUM_VOICES];
  logic [6:0]            vel_q  [NUM_VOICES];
  logic [6:0]            vel_d  [NUM_VOICES];
  logic [AGE_BITS-1:0]   age_q  [NUM_VOICES];
  logic [AGE_BITS-1:0]   age_d  [NUM_VOICES];
  logic [NUM_VOICES-1:0] gate_q, gate_d;
  logic [NUM_VOICES-1:0] trig_q, trig_d;
  logic                  steal_q, steal_d;

  logic                  exec_c, chan_ok_c, note_on_c, note_off_c, all_off_c;
  logic                  found_c;
  logic [IDX_W-1:0]      tgt_c;
  logic [AGE_BITS-1:0]   best_age_c;
  logic [6:0]            d2_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_STATUS;
      status_q   <= '0;
      rs_valid_q <= 1'b0;
      d1_q       <= '0;
      gate_q     <= '0;
      trig_q     <= '0;
      steal_q    <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        note_q[i] <= '0;
        vel_q[i]  <= '0;
        age_q[i]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      status_q   <= status_d;
      rs_valid_q <= rs_valid_d;
      d1_q       <= d1_d;
      gate_q     <= gate_d;
      trig_q     <= trig_d;
      steal_q    <= steal_d;
      for (int i = 0; i < NUM_VOICES; i++) begin
        note_q[i] <= note_d[i];
        vel_q[i]  <= vel_d[i];
        age_q[i]  <= age_d[i];
      end
    end
  end

  always_comb begin
    state_d    = (state_q == ST_EXEC) ? ST_D1 : state_q;
    status_d   = status_q;
    rs_valid_d = rs_valid_q;
    d1_d       = d1_q;
    gate_d     = gate_q;
    trig_d     = '0;
    steal_d    = 1'b0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      note_d[i] = note_q[i];
      vel_d[i]  = vel_q[i];
      age_d[i]  = age_q[i];
    end
    exec_c     = 1'b0;
    found_c    = 1'b0;
    tgt_c      = '0;
    best_age_c = age_q[0];
    d2_c       = midi_data[6:0];

    // Parser; realtime bytes (>= F8) fall through untouched
    if (midi_valid && midi_data < 8'hF8) begin
      if (midi_data >= 8'hF0) begin
        rs_valid_d = 1'b0;
        state_d    = ST_STATUS;
      end else if (midi_data[7]) begin
        status_d   = midi_data;
        rs_valid_d = 1'b1;
        state_d    = ST_D1;
      end else if (state_q == ST_D2) begin
        exec_c  = 1'b1;
        state_d = ST_EXEC;
      end else if (state_q != ST_STATUS || rs_valid_q) begin
        if (status_q[7:5] == 3'b110) begin
          state_d = ST_D1;
        end else begin
          d1_d    = midi_data[6:0];
          state_d = ST_D2;
        end
      end
    end

    chan_ok_c  = exec_c && (status_q[3:0] == 4'(CHANNEL));
    note_on_c  = chan_ok_c && (status_q[7:4] == 4'h9) && (d2_c != 7'd0);
    note_off_c = chan_ok_c && ((status_q[7:4] == 4'h8) ||
                               ((status_q[7:4] == 4'h9) && (d2_c == 7'd0)));
    all_off_c  = chan_ok_c && (status_q[7:4] == 4'hB) &&
                 ((d1_q == 7'd123) || (d1_q == 7'd120));

    // Target: retrigger match, then lowest free voice, then oldest (lowest index on tie)
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (!found_c && gate_q[i] && note_q[i] == d1_q) begin
        found_c = 1'b1;
        tgt_c   = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (!found_c && !gate_q[i]) begin
        found_c = 1'b1;
        tgt_c   = IDX_W'(i);
      end
    end
    if (!found_c) begin
      for (int i = 1; i < NUM_VOICES; i++) begin
        if (age_q[i] > best_age_c) begin
          best_age_c = age_q[i];
          tgt_c      = IDX_W'(i);
        end
      end
    end

    if (note_off_c) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (gate_q[i] && note_q[i] == d1_q) gate_d[i] = 1'b0;
      end
    end

    if (all_off_c) gate_d = '0;

    if (note_on_c) begin
      steal_d       = !found_c;
      note_d[tgt_c] = d1_q;
      vel_d[tgt_c]  = d2_c;
      gate_d[tgt_c] = 1'b1;
      trig_d[tgt_c] = 1'b1;
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (IDX_W'(i) == tgt_c)       age_d[i] = '0;
        else if (age_q[i] != AGE_MAX) age_d[i] = age_q[i] + AGE_BITS'(1);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) begin
      voice_note[7*i +: 7]     = note_q[i];
      voice_velocity[7*i +: 7] = vel_q[i];
    end
  end

  assign voice_gate    = gate_q;
  assign voice_trigger = trig_q;
  assign steal_event   = steal_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: MIDI byte sequences with hand-computed voice state.
module tb_voice_allocator;

  localparam int unsigned NV = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    midi_data;
  logic          midi_valid;
  logic [7*NV-1:0] voice_note, voice_velocity;
  logic [NV-1:0] voice_gate, voice_trigger;
  logic          steal_event;

  int n_cmp = 0;
  int n_bad = 0;

  voice_allocator #(.NUM_VOICES(NV), .AGE_BITS(8), .CHANNEL(0)) dut (
    .clk(clk), .rst(rst), .midi_data(midi_data), .midi_valid(midi_valid),
    .voice_note(voice_note), .voice_velocity(voice_velocity),
    .voice_gate(voice_gate), .voice_trigger(voice_trigger),
    .steal_event(steal_event)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One byte per cycle; returns #1 after the edge that consumed it
  task automatic send(input logic [7:0] b);
    midi_data  = b;
    midi_valid = 1'b1;
    @(posedge clk);
    #1;
    midi_valid = 1'b0;
    midi_data  = 8'h00;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [6:0] note_of(input int i);
    return voice_note[7*i +: 7];
  endfunction

  function automatic logic [6:0] vel_of(input int i);
    return voice_velocity[7*i +: 7];
  endfunction

  initial begin
    rst        = 1'b1;
    midi_data  = 8'h00;
    midi_valid = 1'b0;
    #12;
    check_eq("reset_gate", 32'(voice_gate), 32'h0);
    check_eq("reset_note", 32'(voice_note), 32'h0);
    check_eq("reset_vel",  32'(voice_velocity), 32'h0);
    check_eq("reset_trig", 32'(voice_trigger), 32'h0);
    check_eq("reset_steal", 32'(steal_event), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();

    // Simple note-on
    send(8'h90); send(8'h3C);
    check_eq("t1_early_gate", 32'(voice_gate), 32'h0);
    send(8'h64);
    check_eq("t1_gate",  32'(voice_gate), 32'h1);
    check_eq("t1_note0", 32'(note_of(0)), 32'h3C);
    check_eq("t1_vel0",  32'(vel_of(0)), 32'h64);
    check_eq("t1_trig",  32'(voice_trigger), 32'h1);
    check_eq("t1_steal", 32'(steal_event), 32'h0);
    idle();
    check_eq("t1_trig_clear", 32'(voice_trigger), 32'h0);

    // Running status note-on, then note-off via velocity 0
    send(8'h40); send(8'h50);
    check_eq("t2_gate",  32'(voice_gate), 32'h3);
    check_eq("t2_note1", 32'(note_of(1)), 32'h40);
    check_eq("t2_vel1",  32'(vel_of(1)), 32'h50);
    check_eq("t2_trig",  32'(voice_trigger), 32'h2);
    send(8'h3C); send(8'h00);
    check_eq("t2_off_gate",  32'(voice_gate), 32'h2);
    check_eq("t2_off_note0", 32'(note_of(0)), 32'h3C);
    check_eq("t2_off_trig",  32'(voice_trigger), 32'h0);

    // Retrigger a held note
    send(8'h90); send(8'h3C); send(8'h64);
    check_eq("t4_first_gate", 32'(voice_gate), 32'h3);
    send(8'h90); send(8'h3C); send(8'h20);
    check_eq("t4_vel0",  32'(vel_of(0)), 32'h20);
    check_eq("t4_trig",  32'(voice_trigger), 32'h1);
    check_eq("t4_gate",  32'(voice_gate), 32'h3);
    check_eq("t4_note1", 32'(note_of(1)), 32'h40);
    check_eq("t4_vel1",  32'(vel_of(1)), 32'h50);

    // All notes off
    send(8'hB0); send(8'h7B); send(8'h00);
    check_eq("t6_alloff_gate", 32'(voice_gate), 32'h0);
    check_eq("t6_alloff_trig", 32'(voice_trigger), 32'h0);
    check_eq("t6_alloff_note0", 32'(note_of(0)), 32'h3C);

    // Fill all voices from fresh ages, then steal the oldest
    pulse_reset();
    check_eq("t3_reset_gate", 32'(voice_gate), 32'h0);
    send(8'h90); send(8'h30); send(8'h40);
    send(8'h31); send(8'h40);
    send(8'h32); send(8'h40);
    send(8'h33); send(8'h40);
    check_eq("t3_full_gate",  32'(voice_gate), 32'hF);
    check_eq("t3_full_steal", 32'(steal_event), 32'h0);
    check_eq("t3_note3",      32'(note_of(3)), 32'h33);
    send(8'h34); send(8'h40);
    check_eq("t3_steal",      32'(steal_event), 32'h1);
    check_eq("t3_steal_note0", 32'(note_of(0)), 32'h34);
    check_eq("t3_steal_trig", 32'(voice_trigger), 32'h1);
    check_eq("t3_steal_gate", 32'(voice_gate), 32'hF);
    idle();
    check_eq("t3_steal_clear", 32'(steal_event), 32'h0);
    send(8'h35); send(8'h41);
    check_eq("t3_steal2_note1", 32'(note_of(1)), 32'h35);
    check_eq("t3_steal2_trig",  32'(voice_trigger), 32'h2);
    check_eq("t3_steal2_flag",  32'(steal_event), 32'h1);

    // Explicit note-off (0x80) releases only the matching voice
    send(8'h80); send(8'h32); send(8'h10);
    check_eq("noteoff_gate", 32'(voice_gate), 32'hB);
    check_eq("noteoff_note2", 32'(note_of(2)), 32'h32);

    // Realtime bytes interleaved, then a note on another channel
    send(8'hB0); send(8'h78); send(8'h00);
    check_eq("t5_clear_gate", 32'(voice_gate), 32'h0);
    send(8'h90); send(8'hF8); send(8'h45); send(8'hF8); send(8'h70);
    check_eq("t5_rt_gate",  32'(voice_gate), 32'h1);
    check_eq("t5_rt_note0", 32'(note_of(0)), 32'h45);
    check_eq("t5_rt_vel0",  32'(vel_of(0)), 32'h70);
    send(8'h91); send(8'h3C); send(8'h64);
    check_eq("t5_ch1_gate", 32'(voice_gate), 32'h1);
    check_eq("t5_ch1_trig", 32'(voice_trigger), 32'h0);
    check_eq("t5_ch1_note", 32'(voice_note), {4'h0, 7'h33, 7'h32, 7'h35, 7'h45});

    // Program change data byte is dropped; SysEx clears running status
    send(8'hC0); send(8'h05); send(8'h06);
    check_eq("pc_gate", 32'(voice_gate), 32'h1);
    send(8'hF0); send(8'h3C); send(8'h64);
    check_eq("sysex_gate", 32'(voice_gate), 32'h1);
    check_eq("sysex_trig", 32'(voice_trigger), 32'h0);

    // Reset mid-message discards it
    send(8'h90); send(8'h3C);
    pulse_reset();
    check_eq("rst_mid_gate", 32'(voice_gate), 32'h0);
    check_eq("rst_mid_note", 32'(voice_note), 32'h0);
    send(8'h64);
    check_eq("rst_mid_drop_gate", 32'(voice_gate), 32'h0);
    check_eq("rst_mid_drop_trig", 32'(voice_trigger), 32'h0);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
